msp430_dbg_brk_ctrl: RTL

Debug-side controller that masters the register interface of up to four hardware breakpoint units and acts on their `brk_halt`/`brk_pnd` outputs. It decodes host debug accesses into per-unit register read/write selects and returns the selected unit's data. It also runs the CPU halt/run/single-step state machine that drives the frontend halt request. It sits in the debug unit, between the host debug register port and the breakpoint units/CPU frontend.

---
 rtl/msp430_dbg_brk_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/msp430_dbg_brk_ctrl.sv
// Debug-side breakpoint controller: host register decode for four breakpoint units plus the CPU halt/run/step FSM.
// Optional single-step support is enabled by defining DBG_BRK_ISTEP_EN.
module msp430_dbg_brk_ctrl (
  input  logic        dbg_clk,
  input  logic        dbg_rst,
  input  logic [5:0]  dbg_addr,
  input  logic [15:0] dbg_din,
  input  logic        dbg_wr,
  input  logic        dbg_rd,
  output logic [15:0] dbg_dout,
  output logic [15:0] brk_reg_wr,
  output logic [15:0] brk_reg_rd,
  input  logic [63:0] brk_dout,
  input  logic [3:0]  brk_halt,
  input  logic [3:0]  brk_pnd,
  input  logic        decode_noirq,
  input  logic        cpu_halted,
  output logic        cpu_halt_cmd,
  output logic        dbg_halt_st
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALT_WAIT = 2'd1,
    ST_HALTED    = 2'd2,
    ST_STEP      = 2'd3
  } state_e;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_HOST = 2'b01;
  localparam logic [1:0] CAUSE_BRK  = 2'b10;
  localparam logic [1:0] CAUSE_STEP = 2'b11;

  state_e      state_q, state_d;
  logic [1:0]  cause_q, cause_d;
  logic        hob_q, hob_d;
  logic [15:0] dout_q, dout_d;

  logic        brk_sel;
  logic        ctl_wr;
  logic        stat_wr;
  logic        cmd_halt;
  logic        cmd_run;
  logic        stat_clr;
  logic        brk_trig;
  logic [15:0] rd_data;
  logic [15:0] unit_sel;

  assign brk_sel  = (dbg_addr[5:4] == 2'b01);
  assign unit_sel = 16'(1) << dbg_addr[3:0];
  assign brk_reg_wr = (dbg_wr && brk_sel) ? unit_sel : 16'h0000;
  assign brk_reg_rd = (dbg_rd && brk_sel) ? unit_sel : 16'h0000;

  assign ctl_wr   = dbg_wr && (dbg_addr == 6'h00);
  assign stat_wr  = dbg_wr && (dbg_addr == 6'h01);
  assign cmd_halt = ctl_wr && dbg_din[0];
  assign cmd_run  = ctl_wr && dbg_din[1];
  assign stat_clr = stat_wr && (dbg_din[2:1] == 2'b11);
  assign brk_trig = hob_q && (|brk_halt);

`ifdef DBG_BRK_ISTEP_EN
  logic cmd_istep;
  assign cmd_istep = ctl_wr && dbg_din[2];
`else
  logic unused_noirq;
  assign unused_noirq = decode_noirq;
`endif

  logic unused_din;
  assign unused_din = ^dbg_din[15:4];

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    hob_d   = hob_q;
    if (ctl_wr) hob_d = dbg_din[3];
    if (stat_clr) cause_d = CAUSE_NONE;
    case (state_q)
      ST_RUN: begin
        if (cmd_halt) begin
          state_d = ST_HALT_WAIT;
          cause_d = CAUSE_HOST;
        end else if (brk_trig) begin
          state_d = ST_HALT_WAIT;
          cause_d = CAUSE_BRK;
        end
      end
      ST_HALT_WAIT: begin
        if (cpu_halted) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        // A write carrying both HALT and RUN keeps the CPU stopped.
        if (cmd_run && !cmd_halt) begin
          state_d = ST_RUN;
          cause_d = CAUSE_NONE;
`ifdef DBG_BRK_ISTEP_EN
        end else if (cmd_istep && !cmd_halt) begin
          state_d = ST_STEP;
`endif
        end
      end
      ST_STEP: begin
`ifdef DBG_BRK_ISTEP_EN
        if (brk_trig) begin
          state_d = ST_HALT_WAIT;
          cause_d = CAUSE_BRK;
        end else if (decode_noirq) begin
          state_d = ST_HALT_WAIT;
          cause_d = CAUSE_STEP;
        end
`else
        state_d = ST_RUN;
`endif
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    rd_data = 16'h0000;
    if (dbg_addr == 6'h00) begin
      rd_data = {12'h000, hob_q, 3'b000};
    end else if (dbg_addr == 6'h01) begin
      rd_data = {8'h00, brk_pnd, |brk_pnd, cause_q, (state_q == ST_HALTED)};
    end else if (brk_sel) begin
      rd_data = brk_dout[{dbg_addr[3:2], 4'b0000} +: 16];
    end
  end

  assign dout_d = dbg_rd ? rd_data : dout_q;

  always_ff @(posedge dbg_clk or posedge dbg_rst) begin
    if (dbg_rst) begin
      state_q <= ST_RUN;
      cause_q <= CAUSE_NONE;
      hob_q   <= 1'b1;
      dout_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      hob_q   <= hob_d;
      dout_q  <= dout_d;
    end
  end

  assign dbg_dout     = dout_q;
  assign cpu_halt_cmd = (state_q == ST_HALT_WAIT) || (state_q == ST_HALTED);
  assign dbg_halt_st  = (state_q == ST_HALTED);

endmodule
